// File: rtl/sdram_resp_pkg.sv
// Shared types and constants for the SDRAM stand-in word responder.
package sdram_resp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STALL  = 2'd1,
    ACCEPT = 2'd2
  } resp_state_t;

  localparam logic [31:0] BAD_ADDR_DATA    = 32'hDEADBEEF;
  localparam int unsigned MAX_READ_LATENCY = 8;
  localparam int unsigned MAX_WAIT_CYCLES  = 15;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned BE_W             = DATA_W / 8;
  localparam int unsigned CNT_W            = $clog2(MAX_WAIT_CYCLES + 1);

endpackage

// File: rtl/word_ram_be.sv
// Word-wide RAM with per-byte write enables and a one-cycle registered read port.
module word_ram_be
  import sdram_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Byte-lane writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(BE_W); i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Registered read; holds its value between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/sdram_word_responder.sv
// Avalon-MM word responder: stalled accept, fixed-latency in-order read responses.
module sdram_word_responder
  import sdram_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = 256,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned WAIT_CYCLES  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       slave_address,
  input  logic              slave_read,
  input  logic              slave_write,
  input  logic [DATA_W-1:0] slave_writedata,
  input  logic [BE_W-1:0]   slave_byteenable,
  output logic              slave_waitrequest,
  output logic [DATA_W-1:0] slave_readdata,
  output logic              slave_readdatavalid,
  output logic              protocol_error
);

  localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);

  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
    $error("READ_LATENCY out of range");
  end
  if (WAIT_CYCLES > MAX_WAIT_CYCLES) begin : g_bad_wait
    $error("WAIT_CYCLES out of range");
  end

  resp_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic              req;
  logic              accept;
  logic              in_range;
  logic [ADDR_W-1:0] word_idx;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_q;
  logic              rd_vld0;
  logic              rd_bad0;
  logic [DATA_W-1:0] rd_stage0;
  logic              unused_addr_bits;

  // Address decode and accept-cycle command qualification.
  assign req              = slave_read | slave_write;
  assign accept           = (state == ACCEPT);
  assign word_idx         = slave_address[ADDR_W+1:2];
  assign in_range         = {2'b00, slave_address[31:2]} < 32'(DEPTH_WORDS);
  assign ram_we           = accept & slave_write & in_range;
  assign ram_re           = accept & slave_read & ~slave_write & in_range;
  assign unused_addr_bits = ^slave_address[1:0];

  // Handshake FSM with stall counter, sticky error flag and read-issue tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      slave_waitrequest <= 1'b1;
      protocol_error    <= 1'b0;
      rd_vld0           <= 1'b0;
      rd_bad0           <= 1'b0;
    end else begin
      rd_vld0 <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (WAIT_CYCLES == 0) begin
              state             <= ACCEPT;
              slave_waitrequest <= 1'b0;
            end else begin
              state <= STALL;
              cnt   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        STALL: begin
          if (!req) begin
            protocol_error <= 1'b1;
            state          <= IDLE;
          end else if (cnt == '0) begin
            state             <= ACCEPT;
            slave_waitrequest <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ACCEPT: begin
          state             <= IDLE;
          slave_waitrequest <= 1'b1;
          if (slave_read && !slave_write) begin
            rd_vld0 <= 1'b1;
            rd_bad0 <= ~in_range;
          end
          if ((slave_read && slave_write) || !req) protocol_error <= 1'b1;
        end
        default: begin
          state             <= IDLE;
          slave_waitrequest <= 1'b1;
        end
      endcase
    end
  end

  word_ram_be #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (ram_we),
    .be   (slave_byteenable),
    .addr (word_idx),
    .wdata(slave_writedata),
    .re   (ram_re),
    .rdata(ram_q)
  );

  // Out-of-range reads substitute the marker word after the RAM stage.
  assign rd_stage0 = rd_bad0 ? BAD_ADDR_DATA : ram_q;

  if (READ_LATENCY == 1) begin : g_lat1
    assign slave_readdatavalid = rd_vld0;
    assign slave_readdata      = rd_stage0;
  end else begin : g_latn
    logic [READ_LATENCY-2:0] vld_pipe;
    logic [DATA_W-1:0]       dat_pipe [READ_LATENCY-1];

    // Remaining latency stages; each data stage only loads with a valid so readdata holds.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_pipe <= '0;
        for (int k = 0; k < int'(READ_LATENCY) - 1; k++) dat_pipe[k] <= '0;
      end else begin
        vld_pipe[0] <= rd_vld0;
        if (rd_vld0) dat_pipe[0] <= rd_stage0;
        for (int k = 1; k < int'(READ_LATENCY) - 1; k++) begin
          vld_pipe[k] <= vld_pipe[k-1];
          if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
        end
      end
    end

    assign slave_readdatavalid = vld_pipe[READ_LATENCY-2];
    assign slave_readdata      = dat_pipe[READ_LATENCY-2];
  end

endmodule

// File: tb/tb_sdram_word_responder.sv
// Directed bench: default-parameter responder (a_*) plus a WAIT=3 / LATENCY=5 instance (b_*).
module tb_sdram_word_responder;

  typedef struct {
    logic [31:0] d;
    int          c;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  logic [31:0] a_addr = '0, b_addr = '0;
  logic        a_rd = 1'b0, a_wr = 1'b0, b_rd = 1'b0, b_wr = 1'b0;
  logic [31:0] a_wdata = '0, b_wdata = '0;
  logic [3:0]  a_be = '0, b_be = '0;
  logic        a_wait, b_wait, a_rdv, b_rdv, a_perr, b_perr;
  logic [31:0] a_rdata, b_rdata;

  resp_t a_q[$];
  resp_t b_q[$];

  sdram_word_responder u_dut_a (
    .clk(clk), .rst(rst),
    .slave_address(a_addr), .slave_read(a_rd), .slave_write(a_wr),
    .slave_writedata(a_wdata), .slave_byteenable(a_be),
    .slave_waitrequest(a_wait), .slave_readdata(a_rdata),
    .slave_readdatavalid(a_rdv), .protocol_error(a_perr)
  );

  sdram_word_responder #(.DEPTH_WORDS(256), .READ_LATENCY(5), .WAIT_CYCLES(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .slave_address(b_addr), .slave_read(b_rd), .slave_write(b_wr),
    .slave_writedata(b_wdata), .slave_byteenable(b_be),
    .slave_waitrequest(b_wait), .slave_readdata(b_rdata),
    .slave_readdatavalid(b_rdv), .protocol_error(b_perr)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_rdv === 1'b1) a_q.push_back('{d: a_rdata, c: cyc});
    if (b_rdv === 1'b1) b_q.push_back('{d: b_rdata, c: cyc});
  end

  // One command on the selected port; starts and ends at a negedge, signals cleared after accept.
  task automatic bus_xfer(input int sel, input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output int hi, output int acc, output bit ok);
    if (sel == 0) begin a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = wdata; a_be = be; end
    else          begin b_rd = rd; b_wr = wr; b_addr = addr; b_wdata = wdata; b_be = be; end
    hi = 0; acc = 0; ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (((sel == 0) ? a_wait : b_wait) === 1'b0) begin
        ok = 1'b1; acc = cyc; break;
      end
      hi++;
      @(negedge clk);
    end
    @(negedge clk);
    if (sel == 0) begin a_rd = 1'b0; a_wr = 1'b0; end
    else          begin b_rd = 1'b0; b_wr = 1'b0; end
  endtask

  task automatic get_resp(input int sel, output logic [31:0] d, output int c, output bit ok);
    resp_t r;
    ok = 1'b0; d = '0; c = 0;
    for (int i = 0; i < 40; i++) begin
      if (sel == 0 && a_q.size() > 0) begin r = a_q.pop_front(); ok = 1'b1; break; end
      if (sel != 0 && b_q.size() > 0) begin r = b_q.pop_front(); ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin d = r.d; c = r.c; end
  endtask

  task automatic wr_word(input int sel, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] be);
    int hi, acc; bit ok;
    bus_xfer(sel, 1'b0, 1'b1, addr, data, be, hi, acc, ok);
  endtask

  task automatic rd_word(input int sel, input logic [31:0] addr, output logic [31:0] d,
                         output bit ok);
    int hi, acc, c; bit aok, rok;
    bus_xfer(sel, 1'b1, 1'b0, addr, '0, 4'h0, hi, acc, aok);
    get_resp(sel, d, c, rok);
    ok = aok & rok;
  endtask

  task automatic test_reset();
    checks++; if (a_wait !== 1'b1) begin failures++; $display("FAIL reset_wait got=%b want=1", a_wait); end
    checks++; if (a_rdv !== 1'b0) begin failures++; $display("FAIL reset_rdv got=%b want=0", a_rdv); end
    checks++; if (a_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h want=0", a_rdata); end
    checks++; if (a_perr !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b want=0", a_perr); end
    checks++; if (b_wait !== 1'b1) begin failures++; $display("FAIL reset_wait_b got=%b want=1", b_wait); end
  endtask

  task automatic test_defaults();
    int hi, acc, c; bit ok, rok; logic [31:0] d;
    bus_xfer(0, 1'b0, 1'b1, 32'h10, 32'h12345678, 4'hF, hi, acc, ok);
    checks++; if (!ok || hi != 2) begin failures++; $display("FAIL def_write_stall got=%0d ok=%0d want=2", hi, ok); end
    a_q.delete();
    bus_xfer(0, 1'b1, 1'b0, 32'h10, '0, 4'h0, hi, acc, ok);
    checks++; if (!ok || hi != 2) begin failures++; $display("FAIL def_read_stall got=%0d ok=%0d want=2", hi, ok); end
    get_resp(0, d, c, rok);
    checks++; if (!rok || c - acc != 2) begin failures++; $display("FAIL def_latency got=%0d ok=%0d want=2", c - acc, rok); end
    checks++; if (d !== 32'h12345678) begin failures++; $display("FAIL def_rdata got=%h want=12345678", d); end
    repeat (5) @(negedge clk);
    checks++; if (a_q.size() != 0) begin failures++; $display("FAIL def_extra_pulse got=%0d want=0", a_q.size()); end
    checks++; if (a_rdata !== 32'h12345678) begin failures++; $display("FAIL def_rdata_hold got=%h want=12345678", a_rdata); end
  endtask

  task automatic test_byteenable();
    logic [31:0] d; bit ok;
    wr_word(0, 32'h10, 32'hAABBCCDD, 4'b0101);
    rd_word(0, 32'h10, d, ok);
    checks++; if (!ok || d !== 32'h12BB56DD) begin failures++; $display("FAIL be_merge got=%h ok=%0d want=12bb56dd", d, ok); end
  endtask

  task automatic test_back_to_back();
    int hi[3], acc[3]; bit ok[3]; resp_t r;
    logic [31:0] exp_d[3];
    exp_d[0] = 32'hA0A0_0000; exp_d[1] = 32'hA1A1_0004; exp_d[2] = 32'hA2A2_0008;
    for (int i = 0; i < 3; i++) wr_word(1, 32'(4 * i), exp_d[i], 4'hF);
    b_q.delete();
    for (int i = 0; i < 3; i++) bus_xfer(1, 1'b1, 1'b0, 32'(4 * i), '0, 4'h0, hi[i], acc[i], ok[i]);
    for (int i = 0; i < 3; i++) begin
      checks++; if (!ok[i] || hi[i] != 4) begin failures++; $display("FAIL b2b_stall%0d got=%0d ok=%0d want=4", i, hi[i], ok[i]); end
    end
    for (int i = 0; i < 30 && b_q.size() < 3; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    checks++; if (b_q.size() != 3) begin failures++; $display("FAIL b2b_pulses got=%0d want=3", b_q.size()); end
    for (int i = 0; i < 3; i++) begin
      if (b_q.size() > 0) r = b_q.pop_front(); else r = '{d: 32'hx, c: -1};
      checks++; if (r.d !== exp_d[i]) begin failures++; $display("FAIL b2b_data%0d got=%h want=%h", i, r.d, exp_d[i]); end
      checks++; if (r.c - acc[i] != 5) begin failures++; $display("FAIL b2b_latency%0d got=%0d want=5", i, r.c - acc[i]); end
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; bit ok;
    wr_word(0, 32'h0, 32'h0BAD_F00D, 4'hF);
    wr_word(0, 32'h3FC, 32'hCAFEF00D, 4'hF);
    wr_word(0, 32'h400, 32'h11111111, 4'hF);
    rd_word(0, 32'h400, d, ok);
    checks++; if (!ok || d !== 32'hDEADBEEF) begin failures++; $display("FAIL oor_read got=%h ok=%0d want=deadbeef", d, ok); end
    rd_word(0, 32'h3FC, d, ok);
    checks++; if (!ok || d !== 32'hCAFEF00D) begin failures++; $display("FAIL oor_last_word got=%h ok=%0d want=cafef00d", d, ok); end
    rd_word(0, 32'h0, d, ok);
    checks++; if (!ok || d !== 32'h0BADF00D) begin failures++; $display("FAIL oor_alias got=%h ok=%0d want=0badf00d", d, ok); end
    checks++; if (a_perr !== 1'b0) begin failures++; $display("FAIL oor_perr got=%b want=0", a_perr); end
  endtask

  task automatic test_conflict_and_reset();
    int hi, acc; bit ok; logic [31:0] d;
    a_q.delete();
    bus_xfer(0, 1'b1, 1'b1, 32'h20, 32'h55, 4'hF, hi, acc, ok);
    repeat (8) @(negedge clk);
    checks++; if (a_q.size() != 0) begin failures++; $display("FAIL rw_no_rdv got=%0d want=0", a_q.size()); end
    checks++; if (a_perr !== 1'b1) begin failures++; $display("FAIL rw_perr got=%b want=1", a_perr); end
    rd_word(0, 32'h20, d, ok);
    checks++; if (!ok || d !== 32'h55) begin failures++; $display("FAIL rw_write_done got=%h ok=%0d want=55", d, ok); end
    checks++; if (a_perr !== 1'b1) begin failures++; $display("FAIL rw_perr_sticky got=%b want=1", a_perr); end
    a_q.delete();
    bus_xfer(0, 1'b1, 1'b0, 32'h10, '0, 4'h0, hi, acc, ok);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (a_wait !== 1'b1 || a_rdv !== 1'b0 || a_rdata !== 32'h0 || a_perr !== 1'b0) begin
      failures++;
      $display("FAIL midop_reset got=wait%b rdv%b rdata%h perr%b want=1 0 0 0", a_wait, a_rdv, a_rdata, a_perr);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (a_q.size() != 0) begin failures++; $display("FAIL midop_no_rdv got=%0d want=0", a_q.size()); end
    checks++; if (a_perr !== 1'b0) begin failures++; $display("FAIL midop_perr got=%b want=0", a_perr); end
  endtask

  task automatic test_dma_copy();
    logic [31:0] d; bit ok; logic [31:0] got[4];
    for (int i = 0; i < 4; i++) wr_word(0, 32'h100 + 32'(4 * i), 32'(i + 1), 4'hF);
    wr_word(0, 32'h210, 32'h0000_0077, 4'hF);
    for (int i = 0; i < 4; i++) begin
      rd_word(0, 32'h100 + 32'(4 * i), d, ok);
      wr_word(0, 32'h200 + 32'(4 * i), d, 4'hF);
    end
    for (int i = 0; i < 4; i++) begin
      rd_word(0, 32'h200 + 32'(4 * i), got[i], ok);
      checks++; if (!ok || got[i] !== 32'(i + 1)) begin failures++; $display("FAIL dma_word%0d got=%h ok=%0d want=%h", i, got[i], ok, 32'(i + 1)); end
    end
    rd_word(0, 32'h210, d, ok);
    checks++; if (!ok || d !== 32'h77) begin failures++; $display("FAIL dma_guard got=%h ok=%0d want=77", d, ok); end
    checks++; if (a_perr !== 1'b0) begin failures++; $display("FAIL dma_perr got=%b want=0", a_perr); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_defaults();
    test_byteenable();
    test_back_to_back();
    test_out_of_range();
    test_conflict_and_reset();
    test_dma_copy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
